ddr4_cmd_issuer: RTL

Controller-side DDR4 command generator that drives the command/address pins of the `dimm` emulation model. It accepts one memory request at a time over a valid/ready handshake and tracks the open row of every bank. It issues the minimal ACT / PRE / RD / WR sequence for each request, spacing commands with programmable tRCD, tRP, tRAS and tCCD counters. It sits between the traffic source (AXI front end or test generator) and the DIMM pins. The data path (dq/dqs) belongs to a separate block, which uses this block's `rd_issued`/`wr_issued` pulses.

---
 rtl/ddr4_cmd_pkg.sv | 33 +++
 rtl/ddr4_cmd_issuer_bank_state_table.sv | 65 ++++++
 rtl/ddr4_cmd_issuer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_cmd_pkg.sv
// Shared types and constants for the DDR4 command issuer and its bank table.
package ddr4_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_COL
  } state_e;

  // {ras_n, cas_n, we_n} carried on A16..A14 when act_n=1
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;

  localparam int CMD_HI_POS = 16;
  localparam int CMD_LO_POS = 14;
  localparam int A10_POS    = 10;

  function automatic int cnt_width(input int trcd, input int trp, input int tras,
                                   input int tccd);
    int m;
    m = trcd;
    if (trp > m) m = trp;
    if (tras > m) m = tras;
    if (tccd > m) m = tccd;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ddr4_cmd_issuer_bank_state_table.sv
// Per-bank open/row state with tRAS and tRP down-counters; one lookup port,
// updated by ACT/PRE strobes aimed at the looked-up bank.
module bank_state_table
  import ddr4_cmd_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int TRAS      = 10,
  parameter int TRP       = 4,
  parameter int CNT_W     = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BGWIDTH+BAWIDTH-1:0] lk_bank_i,
  output logic                       lk_open_o,
  output logic [ADDRWIDTH-1:0]       lk_row_o,
  output logic                       lk_tras_zero_o,
  output logic                       lk_trp_zero_o,
  output logic                       lk_trp_last_o,
  input  logic                       act_i,
  input  logic                       pre_i,
  input  logic [ADDRWIDTH-1:0]       act_row_i
);

  localparam int NB = 2 ** (BGWIDTH + BAWIDTH);

  logic                 open_q [NB];
  logic [ADDRWIDTH-1:0] row_q  [NB];
  logic [CNT_W-1:0]     tras_q [NB];
  logic [CNT_W-1:0]     trp_q  [NB];

  assign lk_open_o      = open_q[lk_bank_i];
  assign lk_row_o       = row_q[lk_bank_i];
  assign lk_tras_zero_o = (tras_q[lk_bank_i] == '0);
  assign lk_trp_zero_o  = (trp_q[lk_bank_i] == '0);
  // lets the FSM leave WAIT_RP so the ACT lands on the cycle tRP expires
  assign lk_trp_last_o  = (trp_q[lk_bank_i] <= CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) begin
        open_q[i] <= 1'b0;
        row_q[i]  <= '0;
        tras_q[i] <= '0;
        trp_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (tras_q[i] != '0) tras_q[i] <= tras_q[i] - CNT_W'(1);
        if (trp_q[i] != '0)  trp_q[i]  <= trp_q[i] - CNT_W'(1);
      end
      if (act_i) begin
        open_q[lk_bank_i] <= 1'b1;
        row_q[lk_bank_i]  <= act_row_i;
        tras_q[lk_bank_i] <= CNT_W'(TRAS - 1);
      end
      if (pre_i) begin
        open_q[lk_bank_i] <= 1'b0;
        trp_q[lk_bank_i]  <= CNT_W'(TRP - 1);
      end
    end
  end

endmodule

// File: rtl/ddr4_cmd_issuer.sv
// DDR4 command generator: one request at a time, minimal PRE/ACT/RD/WR
// sequence per request, timing enforced by tRCD/tRP/tRAS/tCCD down-counters.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// DECIDE   | compare request against the bank's open row
// PRE      | wait for tRAS, then precharge the bank
// WAIT_RP  | DES while tRP runs down
// ACT      | wait for tRP, then activate the requested row
// WAIT_RCD | DES while tRCD runs down
// COL      | wait for tCCD, then issue RD/WR
module ddr4_cmd_issuer
  import ddr4_cmd_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TRAS      = 10,
  parameter int TCCD      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 cs_n,
  output logic                 cke,
  output logic                 rd_issued,
  output logic                 wr_issued,
  output logic                 row_hit
);

  localparam int CNT_W = cnt_width(TRCD, TRP, TRAS, TCCD);

  state_e               state_q;
  logic                 req_we_q;
  logic [BGWIDTH-1:0]   req_bg_q;
  logic [BAWIDTH-1:0]   req_ba_q;
  logic [ADDRWIDTH-1:0] req_row_q;
  logic [COLWIDTH-1:0]  req_col_q;
  logic                 hit_q;
  logic [CNT_W-1:0]     rcd_q;
  logic [CNT_W-1:0]     tccd_q;

  logic                 ready_q, cke_q, cs_n_q, act_n_q;
  logic [ADDRWIDTH-1:0] a_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic                 rd_q, wr_q, row_hit_q;

  logic                 bk_open, bk_tras_zero, bk_trp_zero, bk_trp_last;
  logic [ADDRWIDTH-1:0] bk_row;
  logic                 act_stb, pre_stb;

  assign act_stb = (state_q == S_ACT) && bk_trp_zero;
  assign pre_stb = (state_q == S_PRE) && bk_tras_zero;

  bank_state_table #(
    .BGWIDTH  (BGWIDTH),
    .BAWIDTH  (BAWIDTH),
    .ADDRWIDTH(ADDRWIDTH),
    .TRAS     (TRAS),
    .TRP      (TRP),
    .CNT_W    (CNT_W)
  ) u_banks (
    .clk           (clk),
    .reset_n       (reset_n),
    .lk_bank_i     ({req_bg_q, req_ba_q}),
    .lk_open_o     (bk_open),
    .lk_row_o      (bk_row),
    .lk_tras_zero_o(bk_tras_zero),
    .lk_trp_zero_o (bk_trp_zero),
    .lk_trp_last_o (bk_trp_last),
    .act_i         (act_stb),
    .pre_i         (pre_stb),
    .act_row_i     (req_row_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      req_we_q  <= 1'b0;
      req_bg_q  <= '0;
      req_ba_q  <= '0;
      req_row_q <= '0;
      req_col_q <= '0;
      hit_q     <= 1'b0;
      rcd_q     <= '0;
      tccd_q    <= '0;
      ready_q   <= 1'b0;
      cke_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      act_n_q   <= 1'b1;
      a_q       <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      row_hit_q <= 1'b0;
    end else begin
      cke_q     <= 1'b1;
      cs_n_q    <= 1'b1;
      act_n_q   <= 1'b1;
      a_q       <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      row_hit_q <= 1'b0;
      if (rcd_q != '0)  rcd_q  <= rcd_q - CNT_W'(1);
      if (tccd_q != '0) tccd_q <= tccd_q - CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          // ready trails cke by one cycle out of reset
          ready_q <= cke_q;
          if (req_valid && ready_q) begin
            req_we_q  <= req_we;
            req_bg_q  <= req_bg;
            req_ba_q  <= req_ba;
            req_row_q <= req_row;
            req_col_q <= req_col;
            ready_q   <= 1'b0;
            state_q   <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          hit_q <= bk_open && (bk_row == req_row_q);
          if (bk_open && (bk_row == req_row_q)) state_q <= S_COL;
          else if (bk_open)                     state_q <= S_PRE;
          else                                  state_q <= S_ACT;
        end
        S_PRE: begin
          if (bk_tras_zero) begin
            cs_n_q                       <= 1'b0;
            a_q[CMD_HI_POS:CMD_LO_POS]   <= CMD_PRE;
            bg_q                         <= req_bg_q;
            ba_q                         <= req_ba_q;
            state_q                      <= S_WAIT_RP;
          end
        end
        S_WAIT_RP: begin
          if (bk_trp_last) state_q <= S_ACT;
        end
        S_ACT: begin
          if (bk_trp_zero) begin
            cs_n_q  <= 1'b0;
            act_n_q <= 1'b0;
            a_q     <= req_row_q;
            bg_q    <= req_bg_q;
            ba_q    <= req_ba_q;
            rcd_q   <= CNT_W'(TRCD - 1);
            state_q <= S_WAIT_RCD;
          end
        end
        S_WAIT_RCD: begin
          if (rcd_q <= CNT_W'(1)) state_q <= S_COL;
        end
        S_COL: begin
          if (tccd_q == '0) begin
            cs_n_q                     <= 1'b0;
            a_q[CMD_HI_POS:CMD_LO_POS] <= req_we_q ? CMD_WR : CMD_RD;
            a_q[A10_POS]               <= 1'b0;
            a_q[COLWIDTH-1:0]          <= req_col_q;
            bg_q                       <= req_bg_q;
            ba_q                       <= req_ba_q;
            rd_q                       <= !req_we_q;
            wr_q                       <= req_we_q;
            row_hit_q                  <= hit_q;
            tccd_q                     <= CNT_W'(TCCD - 1);
            ready_q                    <= 1'b1;
            state_q                    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign cke       = cke_q;
  assign cs_n      = cs_n_q;
  assign act_n     = act_n_q;
  assign A         = a_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign rd_issued = rd_q;
  assign wr_issued = wr_q;
  assign row_hit   = row_hit_q;

endmodule
